// File: rtl/udp_reg_ring_master_if.sv
// Core-side register bus of the UDP register ring master.
// The master modport is the CPU/core side that raises requests; the slave
// modport is the ring master that completes them.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 32
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

interface udp_reg_ring_master_if;
  // Level request, held high by the core until it sees core_reg_ack.
  logic                            core_reg_req;
  // 1 = read, 0 = write.
  logic                            core_reg_rd_wr_L;
  logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr;
  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data;
  // Returned data, meaningful only while core_reg_ack is high.
  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data;
  // One-cycle completion pulse.
  logic                            core_reg_ack;

  modport master (
    output core_reg_req,
    output core_reg_rd_wr_L,
    output core_reg_addr,
    output core_reg_wr_data,
    input  core_reg_rd_data,
    input  core_reg_ack
  );

  modport slave (
    input  core_reg_req,
    input  core_reg_rd_wr_L,
    input  core_reg_addr,
    input  core_reg_wr_data,
    output core_reg_rd_data,
    output core_reg_ack
  );
endinterface

// File: rtl/udp_reg_ring_master.sv
// UDP register ring master: head of the register ring.
// Takes one core register transaction at a time, launches it as a single
// request word on the ring and completes it when the word comes back from
// the tail carrying our source tag. A word nobody claimed (ack=0) completes
// with 32'hdead_beef.
// Optional build macro REG_RING_MASTER_TIMEOUT_EN adds a watchdog that
// forces completion with 32'hdead_beef after TIMEOUT cycles in WAIT; without
// it the master waits for the returning word indefinitely.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 32
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_ring_master #(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = '0,
  parameter int                           TIMEOUT           = 1024
) (
  input  logic                            clk,
  input  logic                            reset,

  // Core/CPU-side register bus
  udp_reg_ring_master_if.slave            core,

  // Request word launched towards the first responder
  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,

  // Word returning from the last responder
  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
);

  localparam logic [`CPCI_NF2_DATA_WIDTH-1:0] NO_RESPONDER_DATA =
    `CPCI_NF2_DATA_WIDTH'(32'hdead_beef);

  typedef enum logic [2:0] {
    IDLE,     // waiting for a core request
    ISSUE,    // driving the request word onto the ring
    WAIT,     // word is travelling round the ring
    DONE,     // completion pulse to the core
    RELEASE   // waiting for the core to drop its level request
  } state_t;

  state_t                            state_reg;

  // Transaction fields captured in IDLE; the core may change its bus
  // afterwards without disturbing the word in flight.
  logic                              rd_wr_L_reg;
  logic [`UDP_REG_ADDR_WIDTH-1:0]    addr_reg;
  logic [`CPCI_NF2_DATA_WIDTH-1:0]   wr_data_reg;

  // Only our own tag completes a transaction; words from other masters
  // sharing the ring pass by untouched.
  logic                              ret_match;
  assign ret_match = reg_req_in && (reg_src_in == SRC_ID);

  // Address and direction of the returning word are not needed: only one
  // transaction is outstanding, so the tag alone identifies it.
  logic unused_ring_in;
  assign unused_ring_in = &{1'b0, reg_addr_in, reg_rd_wr_L_in};

`ifdef REG_RING_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] timeout_cnt_reg;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Transaction FSM with registered ring and core outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg             <= IDLE;
      rd_wr_L_reg           <= 1'b0;
      addr_reg              <= '0;
      wr_data_reg           <= '0;
      reg_req_out           <= 1'b0;
      reg_ack_out           <= 1'b0;
      reg_rd_wr_L_out       <= 1'b0;
      reg_addr_out          <= '0;
      reg_data_out          <= '0;
      reg_src_out           <= '0;
      core.core_reg_ack     <= 1'b0;
      core.core_reg_rd_data <= '0;
`ifdef REG_RING_MASTER_TIMEOUT_EN
      timeout_cnt_reg       <= '0;
`endif
    end else begin
      // The ring carries an all-zero idle word except during the single
      // launch cycle, and the completion pulse is one cycle wide.
      reg_req_out       <= 1'b0;
      reg_ack_out       <= 1'b0;
      reg_rd_wr_L_out   <= 1'b0;
      reg_addr_out      <= '0;
      reg_data_out      <= '0;
      reg_src_out       <= '0;
      core.core_reg_ack <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (core.core_reg_req) begin
            rd_wr_L_reg <= core.core_reg_rd_wr_L;
            addr_reg    <= core.core_reg_addr;
            wr_data_reg <= core.core_reg_wr_data;
            state_reg   <= ISSUE;
          end
        end

        ISSUE: begin
          reg_req_out     <= 1'b1;
          reg_ack_out     <= 1'b0;
          reg_rd_wr_L_out <= rd_wr_L_reg;
          reg_addr_out    <= addr_reg;
          reg_data_out    <= wr_data_reg;
          reg_src_out     <= SRC_ID;
`ifdef REG_RING_MASTER_TIMEOUT_EN
          timeout_cnt_reg <= '0;
`endif
          state_reg       <= WAIT;
        end

        WAIT: begin
          // A returning word takes priority over a watchdog expiry in the
          // same cycle.
          if (ret_match) begin
            core.core_reg_rd_data <= reg_ack_in ? reg_data_in : NO_RESPONDER_DATA;
            core.core_reg_ack     <= 1'b1;
            state_reg             <= DONE;
          end
`ifdef REG_RING_MASTER_TIMEOUT_EN
          else if (timeout_cnt_reg == TO_LAST) begin
            core.core_reg_rd_data <= NO_RESPONDER_DATA;
            core.core_reg_ack     <= 1'b1;
            state_reg             <= DONE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          state_reg <= RELEASE;
        end

        RELEASE: begin
          // A request still held high after the ack must not launch again.
          if (!core.core_reg_req) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Self-checking bench for udp_reg_ring_master.
// The driver issues core transactions and plays the ring (returning words
// after a chosen delay); expected ring words and expected completions are
// queued, and two monitors compare what the DUT presents.

`timescale 1ns/1ps

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 32
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_ring_master;
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam int SW = 2;
  localparam logic [SW-1:0] SID = 2'd2;
  localparam int TO = 16;
  localparam logic [DW-1:0] DEAD = DW'(32'hdead_beef);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  udp_reg_ring_master_if core_if ();

  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic          reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [DW-1:0] reg_data_in = '0;
  logic [SW-1:0] reg_src_in = '0;

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH (SW),
    .SRC_ID            (SID),
    .TIMEOUT           (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core            (core_if),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } ring_exp_t;
  ring_exp_t ring_q[$];

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } ack_exp_t;
  ack_exp_t ack_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ring monitor: each launched word must be expected, on time and carry
  // the latched fields; otherwise the ring output must be the zero word.
  ring_exp_t re;
  always @(negedge clk) begin
    if (mon_en) begin
      if (reg_req_out === 1'b1) begin
        if (ring_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_req_out: got reg_req_out=1, expected 0 (cycle %0d)", cyc);
        end else begin
          re = ring_q.pop_front();
          check("ring_cycle", 128'(cyc), 128'(re.cyc));
          check("ring_ack_out", 128'(reg_ack_out), 128'(0));
          check("ring_src_out", 128'(reg_src_out), 128'(SID));
          check("ring_rd_wr_L_out", 128'(reg_rd_wr_L_out), 128'(re.rd));
          check("ring_addr_out", 128'(reg_addr_out), 128'(re.addr));
          check("ring_data_out", 128'(reg_data_out), 128'(re.data));
        end
      end else begin
        check("ring_idle_word",
              {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_src_out, reg_addr_out, reg_data_out},
              128'(0));
      end
    end
  end

  // Completion monitor: every ack pulse must match the next expected one.
  ack_exp_t ae;
  always @(negedge clk) begin
    if (mon_en && (core_if.core_reg_ack !== 1'b0)) begin
      if (ack_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ack: got core_reg_ack=%b, expected 0 (cycle %0d)", core_if.core_reg_ack, cyc);
      end else begin
        ae = ack_q.pop_front();
        check("ack_cycle", 128'(cyc), 128'(ae.cyc));
        check("rd_data", 128'(core_if.core_reg_rd_data), 128'(ae.data));
      end
    end
  end

  task automatic drive_ret(input logic req, input logic [SW-1:0] src, input logic ack, input logic [DW-1:0] d);
    reg_req_in     = req;
    reg_src_in     = src;
    reg_ack_in     = ack;
    reg_data_in    = d;
    reg_addr_in    = AW'($urandom);
    reg_rd_wr_L_in = 1'($urandom);
  endtask

  task automatic idle_ret();
    drive_ret(1'b0, SW'($urandom), 1'($urandom), DW'($urandom));
  endtask

  // mode: 0 = responder claims, 1 = nobody claims, 2 = no return (watchdog)
  task automatic run_txn(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int mode, input int delay, input bit foreign, input int hold,
                         input bit late, input logic [DW-1:0] rdata);
    int c;
    bit seen;
    logic [DW-1:0] exp;
    exp = (mode == 0) ? rdata : DEAD;
    @(negedge clk);
    core_if.core_reg_req     = 1'b1;
    core_if.core_reg_rd_wr_L = rd;
    core_if.core_reg_addr    = addr;
    core_if.core_reg_wr_data = wdata;
    c = cyc;
    ring_q.push_back('{rd, addr, wdata, c + 2});
    @(negedge clk);
    core_if.core_reg_rd_wr_L = 1'($urandom);
    core_if.core_reg_addr    = AW'($urandom);
    core_if.core_reg_wr_data = DW'($urandom);
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      seen = (reg_req_out === 1'b1);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL no_req_out: got no ring request, expected one at cycle %0d", c + 2);
      ring_q.delete();
      core_if.core_reg_req = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    if (mode == 2) begin
      ack_q.push_back('{DEAD, c + 2 + TO});
    end else begin
      for (int k = 0; k < delay; k++) begin
        if (foreign && k == 0) drive_ret(1'b1, SID ^ SW'($urandom_range(1, 3)), 1'b1, DW'($urandom));
        else idle_ret();
        @(negedge clk);
      end
      drive_ret(1'b1, SID, (mode == 0), (mode == 0) ? rdata : DW'($urandom));
      ack_q.push_back('{exp, cyc + 1});
      @(negedge clk);
      idle_ret();
    end
    seen = 1'b0;
    for (int t = 0; t < TO + 8 && !seen; t++) begin
      if (core_if.core_reg_ack === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL no_ack: got no core_reg_ack, expected rd_data %0h", exp);
      ack_q.delete();
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (late && k == 0) drive_ret(1'b1, SID, 1'b1, DW'($urandom));
      else idle_ret();
    end
    @(negedge clk);
    idle_ret();
    core_if.core_reg_req = 1'b0;
    @(negedge clk);
    $display("[TB] txn rd=%0b addr=%h wdata=%h mode=%0d delay=%0d foreign=%0b hold=%0d exp_rd_data=%h",
             rd, addr, wdata, mode, delay, foreign, hold, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    core_if.core_reg_req     = 1'b0;
    core_if.core_reg_rd_wr_L = 1'b0;
    core_if.core_reg_addr    = '0;
    core_if.core_reg_wr_data = '0;
    idle_ret();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ring_word",
          {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_src_out, reg_addr_out, reg_data_out}, 128'(0));
    check("reset_core_ack", 128'(core_if.core_reg_ack), 128'(0));
    check("reset_rd_data", 128'(core_if.core_reg_rd_data), 128'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(1'b1, AW'(32'h2000004), DW'($urandom), 0, 3, 1'b0, 0, 1'b0, DW'(32'h12345678));
    run_txn(1'b0, AW'(32'h2000001), DW'(32'hA5A5A5A5), 0, 2, 1'b0, 0, 1'b0, DW'($urandom));
    run_txn(1'b1, AW'(32'h3000010), DW'($urandom), 1, 1, 1'b0, 0, 1'b0, DW'($urandom));
    run_txn(1'b1, AW'(32'h2000008), DW'($urandom), 0, 4, 1'b1, 10, 1'b0, DW'(32'hCAFE0001));
    run_txn(1'b0, AW'(32'h2000002), DW'(32'h5A5A5A5A), 0, 0, 1'b0, 1, 1'b0, DW'($urandom));
`ifdef REG_RING_MASTER_TIMEOUT_EN
    run_txn(1'b1, AW'(32'h7000000), DW'($urandom), 2, 0, 1'b0, 3, 1'b1, DW'($urandom));
    run_txn(1'b1, AW'(32'h2000004), DW'($urandom), 0, 2, 1'b0, 0, 1'b0, DW'(32'h0BADF00D));
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(0, 6);
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 1), d,
              (d > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3),
              1'($urandom), DW'($urandom));
    end

    // Reset while the word is on the ring: no completion, late word dropped
    @(negedge clk);
    core_if.core_reg_req     = 1'b1;
    core_if.core_reg_rd_wr_L = 1'b1;
    core_if.core_reg_addr    = AW'(32'h2000004);
    core_if.core_reg_wr_data = DW'(32'h11112222);
    ring_q.push_back('{1'b1, AW'(32'h2000004), DW'(32'h11112222), cyc + 2});
    repeat (4) @(negedge clk);
    reset = 1'b1;
    core_if.core_reg_req = 1'b0;
    @(negedge clk);
    check("midreset_ring_word",
          {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_src_out, reg_addr_out, reg_data_out}, 128'(0));
    check("midreset_core_ack", 128'(core_if.core_reg_ack), 128'(0));
    check("midreset_rd_data", 128'(core_if.core_reg_rd_data), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    drive_ret(1'b1, SID, 1'b1, DW'(32'h99999999));
    @(negedge clk);
    idle_ret();
    for (int k = 0; k < 5; k++) begin
      check("midreset_no_ack", 128'(core_if.core_reg_ack), 128'(0));
      @(negedge clk);
    end
    $display("[TB] txn reset-abort addr=%h", AW'(32'h2000004));

    run_txn(1'b1, AW'(32'h2000004), DW'($urandom), 0, 1, 1'b0, 0, 1'b0, DW'(32'h600DCAFE));

    repeat (5) @(negedge clk);
    check("ring_queue_drained", 128'(ring_q.size()), 128'(0));
    check("ack_queue_drained", 128'(ack_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_reg_ring_master.md
Name: udp_reg_ring_master

Overview:
- Initiator at the head of the UDP register ring.
- Accepts single register transactions (read or write) from the core/CPU-side register bus and launches each as one request word on the ring.
- Consumes the word that returns from the tail of the ring and hands the read data and completion back to the core side.
- Pairs with the per-block register responders, which ack and fill data as the word passes through them.

Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the ring source tag.
- SRC_ID, 0, source tag stamped on launched requests; returning words are matched against it.
- TIMEOUT, 1024, cycles to wait for the returning word before forcing completion (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- core_reg_req  in  1  level request from core side; held high until core_reg_ack.
- core_reg_rd_wr_L  in  1  1 = read, 0 = write.
- core_reg_addr  in  `UDP_REG_ADDR_WIDTH  target address.
- core_reg_wr_data  in  `CPCI_NF2_DATA_WIDTH  write data.
- core_reg_rd_data  out  `CPCI_NF2_DATA_WIDTH  returned data; valid when core_reg_ack=1.
- core_reg_ack  out  1  one-cycle completion pulse.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring request word to the first responder.
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring address.
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring data.
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring source tag.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring word returning from the last responder.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  returning address.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  returning data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  returning source tag.

Behaviour:
- Reset values:
  - All ring outputs are 0.
  - core_reg_ack = 0 and core_reg_rd_data = 0.
  - State = IDLE; timeout counter = 0.
- States:
  - IDLE: if core_reg_req=1, latch rd_wr_L, addr and wr_data, then go to ISSUE.
  - ISSUE: registered outputs give reg_req_out=1, reg_ack_out=0, reg_src_out=SRC_ID and the latched fields for exactly one cycle. Next state is WAIT.
    - Latency: core_reg_req sampled at edge N gives reg_req_out=1 after edge N+1.
  - WAIT:
    - A returning word with reg_req_in=1 and reg_src_in==SRC_ID completes the transaction.
    - If reg_ack_in=1: core_reg_rd_data <= reg_data_in.
    - If reg_ack_in=0 (no responder claimed the address): core_reg_rd_data <= 32'hdead_beef.
    - Writes return data identically; the core side ignores it.
    - In all cases core_reg_ack pulses 1 on the following cycle; next state is DONE.
  - DONE: core_reg_ack=1 for exactly one cycle, then go to RELEASE.
  - RELEASE: wait for core_reg_req=0, then go to IDLE. This prevents a held request from being re-issued.
- Outside ISSUE, reg_req_out=0 and ring outputs hold 0.
- Only one transaction is outstanding at a time.
- Returning words are discarded in these cases:
  - reg_req_in=1 with a foreign src in any state.
  - reg_req_in=1 in IDLE, ISSUE, DONE or RELEASE.
- Returning word in the same cycle as the timeout expiry: the returned word wins.
- Changes on the core_reg_* inputs after latching have no effect on the in-flight word.
- Reset asserted mid-transaction aborts it: no ack is given, and a late returning word is dropped.

Optional Feature:
- Macro REG_RING_MASTER_TIMEOUT_EN.
- Defined:
  - WAIT increments a counter of width log2(TIMEOUT)+1, cleared on entry to WAIT.
  - When the counter reaches TIMEOUT-1 with no matching return, the block completes with core_reg_rd_data=32'hdead_beef and goes to DONE.
  - A word arriving after the timeout is discarded.
- Undefined: no counter is built, and WAIT waits indefinitely.

Test Plan:
- Read, responder present: core read addr=0x2000004; ring returns req=1, ack=1, src=SRC_ID, data=0x12345678 three cycles later -> reg_req_out high exactly one cycle; core_reg_ack pulses once with rd_data=0x12345678.
- Write: core write addr=0x2000001, wr_data=0xA5A5A5A5 -> ring word has rd_wr_L=0, data=0xA5A5A5A5, ack=0; completes on the matching return.
- Unclaimed address: return has ack=0 -> rd_data=0xdeadbeef, one ack pulse.
- Foreign src and held request: a return with src != SRC_ID during WAIT is ignored; core_reg_req held high for 10 cycles after ack -> no second reg_req_out.
- Timeout (macro defined, TIMEOUT=16): no return -> ack with 0xdeadbeef 16 cycles after entering WAIT; a later matching word is dropped and the next request works normally.
- Reset in WAIT: assert reset one cycle -> all outputs 0; a subsequent return gives no core_reg_ack.
